// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants for the seven-segment scan controller:
//                digit count, active-low hex font ({g,f,e,d,c,b,a}),
//                blank segment pattern and scan FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

   localparam int DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low hex font, index = nibble value: 0-9, A, b, C, d, E, F
   localparam logic [6:0] SEG_FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg_dec
//  Description : Combinational 4-bit hex to 7-segment active-low decoder.
//  Ports       : hex - nibble to display
//                seg - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_FONT[hex];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit common-anode
//                seven-segment display. Holds a value/dp register file and
//                strobes the enabled digits one slot at a time, with a blanking
//                gap at the start of every slot.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                wr_en/addr/data/dp  - register file write port
//                digit_en            - per-digit enable mask
//                seg, dp, an         - display pins, all active-low
//                scan_idx            - digit owning the current slot
//                slot_tick           - pulse on last cycle of each slot
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              wr_dp,
   input  logic [DIGITS-1:0] digit_en,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic [2:0]        scan_idx,
   output logic              slot_tick
);

   localparam int               CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] SHOW_START = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              wrap;
   state_e            state;
   state_e            state_next;
   logic [2:0]        idx;
   logic [2:0]        idx_next;
   logic [3:0]        values [DIGITS];
   logic [DIGITS-1:0] dps;
   logic [6:0]        rd_seg;
   logic              show;

   // ---------------------------------------------------------------- counter
   assign wrap     = (cnt == CNT_LAST);
   assign cnt_next = wrap ? '0 : cnt + 1'b1;

   // An empty mask pins the FSM in BLANK; otherwise the state simply follows
   // the position of the counter inside the slot.
   always_comb begin
      state_next = BLANK;
      if (digit_en != '0 && cnt_next >= SHOW_START) begin
         state_next = SHOW;
      end
   end

   // Next enabled digit above idx, modulo 8. Scanning the offsets downward
   // lets the nearest candidate win; offset 8 is idx itself, so a lone
   // enabled digit keeps its slot and an empty mask leaves idx untouched.
   always_comb begin
      logic [2:0] cand;
      idx_next = idx;
      for (int k = DIGITS; k >= 1; k--) begin
         cand = idx + 3'(k);
         if (digit_en[cand]) begin
            idx_next = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         state <= BLANK;
         idx   <= '0;
      end else begin
         cnt   <= cnt_next;
         state <= state_next;
         if (wrap) begin
            idx <= idx_next;
         end
      end
   end

   // ---------------------------------------------------------- register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            values[i] <= '0;
         end
         dps <= '0;
      end else if (wr_en) begin
         values[wr_addr] <= wr_data;
         dps[wr_addr]    <= wr_dp;
      end
   end

   hex7seg_dec u_dec (
      .hex (values[idx]),
      .seg (rd_seg)
   );

   // ------------------------------------------------------- output registers
   // Gating on digit_en[idx] blanks a digit that is disabled mid-slot on the
   // very next edge rather than waiting for the wrap.
   assign show = (state == SHOW) && digit_en[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
         an        <= '1;
         scan_idx  <= '0;
         slot_tick <= 1'b0;
      end else begin
         slot_tick <= wrap;
         scan_idx  <= idx;
         if (show) begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= rd_seg;
            dp  <= ~dps[idx];
         end else begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_ctrl
//  Description : Self-checking bench for seven_seg_scan_ctrl with
//                REFRESH_DIV=8, BLANK_CYCLES=2 and a slot-level display model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

   localparam int RD = 8;
   localparam int BC = 2;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       wr_en    = 1'b0;
   logic [2:0] wr_addr  = '0;
   logic [3:0] wr_data  = '0;
   logic       wr_dp    = 1'b0;
   logic [7:0] digit_en = 8'h01;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic [2:0] scan_idx;
   logic       slot_tick;

   int vectors    = 0;
   int miscompares = 0;

   seven_seg_scan_ctrl #(
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_dp     (wr_dp),
      .digit_en  (digit_en),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .scan_idx  (scan_idx),
      .slot_tick (slot_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang want finish");
      $fatal(1);
   end

   // ------------------------------------------------------------ reference model
   // mpos = slot position that the next edge displays; mcur = owning digit.
   int         mpos;
   int         mcur;
   logic [3:0] mval [8];
   logic       mdp  [8];
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic [7:0] exp_an;
   logic [2:0] exp_idx;
   logic       exp_tick;

   function automatic logic [6:0] font(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic int next_en(input int cur, input logic [7:0] en);
      for (int k = 1; k <= 8; k++) begin
         if (en[(cur + k) % 8]) return (cur + k) % 8;
      end
      return cur;
   endfunction

   task automatic model_reset();
      mpos = 0;
      mcur = 0;
      for (int i = 0; i < 8; i++) begin
         mval[i] = 4'h0;
         mdp[i]  = 1'b0;
      end
   endtask

   // Called right at a rising edge, with the inputs the DUT samples there.
   task automatic model_edge();
      logic lit;
      lit      = (mpos >= BC) && digit_en[mcur];
      exp_tick = (mpos == RD - 1);
      exp_idx  = 3'(mcur);
      exp_an   = lit ? ~(8'd1 << mcur) : 8'hFF;
      exp_seg  = lit ? font(mval[mcur]) : 7'h7F;
      exp_dp   = lit ? ~mdp[mcur] : 1'b1;
      if (wr_en) begin
         mval[wr_addr] = wr_data;
         mdp[wr_addr]  = wr_dp;
      end
      if (mpos == RD - 1) mcur = next_en(mcur, digit_en);
      mpos = (mpos + 1) % RD;
   endtask

   function automatic logic [19:0] exp_vec();
      return {exp_an, exp_seg, exp_dp, exp_idx, exp_tick};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {an, seg, dp, scan_idx, slot_tick};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ------------------------------------------------------------------- tests
   task automatic test_reset();
      int lit_cnt;
      #12;
      vectors++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || scan_idx !== 3'd0 || slot_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got an=%h seg=%h dp=%b idx=%0d tick=%b, want an=ff seg=7f dp=1 idx=0 tick=0",
                  an, seg, dp, scan_idx, slot_tick);
      end
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      lit_cnt = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_release cyc %0d: got {an,seg,dp,idx,tick}=%h want %h", c, dut_vec(), exp_vec());
         end
         if (c < 16 && an == 8'hFE && seg == 7'b1000000) lit_cnt++;
      end
      vectors++;
      if (lit_cnt !== 12) begin
         miscompares++;
         $display("FAIL reset_duty: got %0d lit cycles of 16, want 12", lit_cnt);
      end
   endtask

   task automatic test_full_scan();
      int ticks;
      logic [7:0] seen;
      for (int d = 0; d < 8; d++) begin
         wr_en = 1'b1; wr_addr = 3'(d); wr_data = 4'(d); wr_dp = d[0];
         tick();
      end
      wr_en = 1'b0;
      digit_en = 8'hFF;
      ticks = 0;
      seen  = '0;
      for (int c = 0; c < 80; c++) begin
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL full_scan cyc %0d: got {an,seg,dp,idx,tick}=%h want %h", c, dut_vec(), exp_vec());
         end
         if (c < 64 && slot_tick) ticks++;
         if (an != 8'hFF) seen = seen | ~an;
      end
      vectors++;
      if (ticks !== 8 || seen !== 8'hFF) begin
         miscompares++;
         $display("FAIL full_scan_cover: got ticks=%0d strobed=%h, want ticks=8 strobed=ff", ticks, seen);
      end
   endtask

   task automatic test_skip();
      logic [7:0] seen;
      digit_en = 8'b1000_0101;
      seen = '0;
      for (int c = 0; c < 96; c++) begin
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL skip cyc %0d: got {an,seg,dp,idx,tick}=%h want %h", c, dut_vec(), exp_vec());
         end
         if (c >= 16 && an != 8'hFF) seen = seen | ~an;
      end
      vectors++;
      if (seen !== 8'h85) begin
         miscompares++;
         $display("FAIL skip_strobes: got strobed=%h want 85", seen);
      end
   endtask

   task automatic test_live_write();
      bit found;
      digit_en = 8'hFF;
      found = 0;
      for (int c = 0; c < 128 && !found; c++) begin
         tick();
         if (exp_an == 8'hF7 && mpos >= 3 && mpos <= 6) found = 1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL live_write_wait: got no digit 3 SHOW within 128 cycles, want one");
      end else begin
         wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF; wr_dp = 1'b1;
         tick();
         wr_en = 1'b0;
         tick();
         vectors++;
         if (seg !== 7'b0001110 || dp !== 1'b0 || an !== 8'hF7) begin
            miscompares++;
            $display("FAIL live_write: got seg=%b dp=%b an=%h, want seg=0001110 dp=0 an=f7", seg, dp, an);
         end
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL live_write_model: got %h want %h", dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_empty_mask();
      bit found;
      int ticks;
      logic [2:0] frozen;
      found = 0;
      for (int c = 0; c < 64 && !found; c++) begin
         tick();
         if (exp_an != 8'hFF && mpos >= 3 && mpos <= 6) found = 1;
      end
      frozen = scan_idx;
      digit_en = 8'h00;
      ticks = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         vectors++;
         if (an !== 8'hFF || scan_idx !== frozen || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL empty_mask cyc %0d: got an=%h idx=%0d vec=%h, want an=ff idx=%0d vec=%h",
                     c, an, scan_idx, dut_vec(), frozen, exp_vec());
         end
         if (slot_tick) ticks++;
      end
      vectors++;
      if (!found || ticks !== 3) begin
         miscompares++;
         $display("FAIL empty_mask_tick: got found=%0d ticks=%0d, want found=1 ticks=3", found, ticks);
      end
   endtask

   task automatic test_async_reset();
      bit found;
      int hits;
      // Leave the empty-mask state through a clean reset, then load digits.
      rst_n = 1'b0;
      @(negedge clk);
      model_reset();
      digit_en = 8'hFF;
      rst_n = 1'b1;
      for (int d = 0; d < 8; d++) begin
         wr_en = 1'b1; wr_addr = 3'(d); wr_data = 4'(8 + d); wr_dp = 1'b1;
         tick();
      end
      wr_en = 1'b0;
      found = 0;
      for (int c = 0; c < 128 && !found; c++) begin
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_pre cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
         end
         if (exp_an == 8'hDF && mpos >= 3) found = 1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (!found || an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || scan_idx !== 3'd0) begin
         miscompares++;
         $display("FAIL async_reset: got found=%0d an=%h seg=%h dp=%b idx=%0d, want found=1 an=ff seg=7f dp=1 idx=0",
                  found, an, seg, dp, scan_idx);
      end
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_post cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
         end
         if (an == 8'hDF && seg == 7'b1000000 && dp == 1'b1) hits++;
      end
      vectors++;
      if (hits !== 6) begin
         miscompares++;
         $display("FAIL async_cleared: got %0d cleared digit-5 cycles, want 6", hits);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         wr_en   = ($urandom_range(0, 2) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 4'($urandom_range(0, 15));
         wr_dp   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom_range(1, 255));
         tick();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random cyc %0d en=%h: got {an,seg,dp,idx,tick}=%h want %h",
                     c, digit_en, dut_vec(), exp_vec());
         end
      end
      wr_en = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_scan();
      test_skip();
      test_live_write();
      test_empty_mask();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds one 4-bit hex value plus a decimal-point bit per digit in an internal register file, and cycles through the enabled digits one at a time. For each digit it drives the shared `seg`/`dp` lines and a one-hot-low `an` strobe, inserting a blanking gap between digits to suppress ghosting. It sits between the system logic, which writes digit values, and the display pins, replacing static per-digit `num`/`sel` driving.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write strobe for the digit register file.
- `wr_addr` in 3: digit index to write (0 = rightmost).
- `wr_data` in 4: hex value 0x0–0xF.
- `wr_dp` in 1: decimal point for that digit (1 = lit).
- `digit_en` in 8: per-digit enable mask; disabled digits are skipped.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 8: anode strobes, active-low, at most one bit low.
- `scan_idx` out 3: digit currently owning the slot.
- `slot_tick` out 1: single-cycle pulse on the last cycle of each slot.

## Operation
- Register file: 8 × {4-bit value, dp}. A write is accepted every cycle `wr_en`=1; it cannot be refused. Reset clears all entries to value 0, dp 0.
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1 and wraps. `slot_tick`=1 when `cnt`=`REFRESH_DIV`-1.
- FSM, two states:
  - BLANK (`cnt` < `BLANK_CYCLES`): `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - SHOW (otherwise): `an` has bit `scan_idx` low; `seg` = decode(value[`scan_idx`]); `dp` = ~dp[`scan_idx`].
  - BLANK→SHOW when `cnt` reaches `BLANK_CYCLES`. SHOW→BLANK on wrap.
- Advance: on wrap, `scan_idx` moves to the next index above the current one, modulo 8, whose `digit_en` bit is 1. If only the current digit is enabled, `scan_idx` stays. If `digit_en`=0, `scan_idx` holds, the FSM is forced to BLANK and outputs stay blanked; the counter keeps running.
- If `digit_en[scan_idx]` drops during SHOW, `an`/`seg` blank from the next cycle. `scan_idx` advances normally at wrap.
- Decode: standard hex font 0–9, A, b, C, d, E, F, active-low. 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110.

## Timing
- All outputs are registered. Reset values: `seg`=7'h7F, `dp`=1, `an`=8'hFF, `scan_idx`=0, `slot_tick`=0, `cnt`=0, FSM=BLANK.
- After reset release, the first SHOW of digit 0 starts `BLANK_CYCLES`+1 edges later, provided `digit_en[0]`=1. Otherwise digit 0's slot stays blank and scanning proceeds from the first wrap.
- Write latency: a write sampled at edge N changes `seg`/`dp` at edge N+1 when it targets the digit being shown.
- A simultaneous write and wrap is fine: the write lands in the register file, and the new digit's output uses the post-write value.
- Asserting reset mid-slot blanks outputs immediately (asynchronously) and restarts at digit 0.
- One full scan period = `REFRESH_DIV` × (number of enabled digits).

## Structure
- Package `seg_pkg`: digit-count constant (8), the hex→segment font as a localparam array, `SEG_BLANK`=7'h7F, and the FSM state enum {BLANK, SHOW}.
- One sub-module: `hex7seg_dec`, a purely combinational 4-bit → 7-bit active-low decoder using the package font. It is instantiated once on the register-file read port.
- Top holds the counter, FSM, register file, next-enabled-index search and output registers.

## Test plan
Use `REFRESH_DIV`=8, `BLANK_CYCLES`=2 for all cases.
- Reset: with `rst_n`=0 → `an`=8'hFF, `seg`=7'h7F, `dp`=1, `scan_idx`=0. Release with `digit_en`=8'h01 and digit 0 = 0 → `an`=8'hFE, `seg`=7'b1000000 for 6 of every 8 cycles, blank for the other 2.
- Full scan: write 0..7 to digits 0..7 with `digit_en`=8'hFF → `an` cycles FE, FD, … 7F every 8 cycles with matching decode. `slot_tick` pulses every 8 cycles, and the pattern wraps back to digit 0.
- Skip: `digit_en`=8'b1000_0101 → `scan_idx` sequence 0, 2, 7, 0. Digits 1 and 3–6 never strobe.
- Live write: during digit 3's SHOW, write 0xF with dp=1 → next cycle `seg`=7'b0001110, `dp`=0, `an` unchanged.
- Empty mask: set `digit_en`=0 mid-SHOW → `an`=8'hFF from the next cycle onward; `scan_idx` frozen; `slot_tick` still pulses.
- Async reset: assert `rst_n`=0 mid-SHOW of digit 5 → outputs blank with no clock edge; after release, scan restarts at digit 0 with all values cleared.
